// File: rtl/ft_tx_framer.sv
// rtl/ft_tx_framer.sv - FT245 reply framer: 0x55 header, RAM payload, 0xAA trailer, FT_WR handshake
// Optional FT_TX_TIMEOUT_EN: abort with error after TIMEOUT_CYCLES stalled in WAIT_TXE.
module ft_tx_framer #(
  parameter logic [7:0] HEADER_KEY_SYMBOL         = 8'd85,
  parameter int         HEADER_KEY_SYMBOL_NUMBER  = 12,
  parameter logic [7:0] TRAILER_KEY_SYMBOL        = 8'd170,
  parameter int         TRAILER_KEY_SYMBOL_NUMBER = 8,
  parameter logic [7:0] ERROR_SYMBOL              = 8'hEE,
  parameter int         MAX_PAYLOAD               = 256,
  parameter int         WR_PULSE_CYCLES           = 3,
  parameter int         WR_GAP_CYCLES             = 2,
  parameter int         TIMEOUT_CYCLES            = 65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [8:0] payload_len,
  output logic       rd_en,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       FT_TXEn,
  output logic       FT_WR,
  output logic [7:0] FT_DATA_Out,
  output logic       FT_DATA_OE
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_WAIT_TXE, S_STROBE, S_HOLD, S_GAP, S_DONE
  } state_t;

  typedef enum logic [1:0] {SEC_HDR, SEC_PAY, SEC_TRL} section_t;

  localparam logic [8:0] HDR_LAST   = 9'(HEADER_KEY_SYMBOL_NUMBER - 1);
  localparam logic [8:0] TRL_LAST   = 9'(TRAILER_KEY_SYMBOL_NUMBER - 1);
  localparam logic [8:0] MAX_LEN    = 9'(MAX_PAYLOAD);
  localparam logic [7:0] PULSE_LAST = 8'(WR_PULSE_CYCLES - 1);
  localparam logic [7:0] GAP_LAST   = 8'(WR_GAP_CYCLES - 1);

  state_t     state_q, state_d;
  section_t   section_q;
  logic [8:0] idx_q, len_q;
  logic [7:0] byte_q, cnt_q;
  logic       err_q;
  logic       txe_s1, txe_s2, txe_ok;
  logic       last_byte, bad_len, timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txe_s1 <= 1'b1;
      txe_s2 <= 1'b1;
    end else begin
      txe_s1 <= FT_TXEn;
      txe_s2 <= txe_s1;
    end
  end

  assign txe_ok  = ~txe_s2;
  assign bad_len = (payload_len == 9'd0) || (payload_len > MAX_LEN);

`ifdef FT_TX_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] to_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    to_cnt_q <= '0;
    else if (state_q == S_WAIT_TXE) to_cnt_q <= to_cnt_q + 16'd1;
    else                           to_cnt_q <= '0;
  end

  assign timeout = (state_q == S_WAIT_TXE) && !txe_ok && (to_cnt_q == TO_LAST);
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    last_byte = 1'b0;
    case (section_q)
      SEC_HDR: last_byte = (idx_q == HDR_LAST);
      SEC_PAY: last_byte = (idx_q == len_q - 9'd1);
      default: last_byte = (idx_q == TRL_LAST);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start) state_d = S_FETCH;
      S_FETCH:    state_d = (section_q == SEC_PAY) ? S_LOAD : S_WAIT_TXE;
      S_LOAD:     state_d = S_WAIT_TXE;
      S_WAIT_TXE: begin
        if (txe_ok)       state_d = S_STROBE;
        else if (timeout) state_d = S_DONE;
      end
      S_STROBE:   if (cnt_q == PULSE_LAST) state_d = S_HOLD;
      S_HOLD:     state_d = S_GAP;
      S_GAP: begin
        if (cnt_q == GAP_LAST)
          state_d = (last_byte && section_q == SEC_TRL) ? S_DONE : S_FETCH;
      end
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      section_q <= SEC_HDR;
      idx_q     <= '0;
      len_q     <= '0;
      byte_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      cnt_q <= (state_d != state_q) ? 8'd0 : cnt_q + 8'd1;
      case (state_q)
        S_IDLE: if (start) begin
          section_q <= SEC_HDR;
          idx_q     <= '0;
          err_q     <= bad_len;
          len_q     <= bad_len ? 9'd1 : payload_len;
        end
        S_FETCH: begin
          if (section_q == SEC_HDR)      byte_q <= HEADER_KEY_SYMBOL;
          else if (section_q == SEC_TRL) byte_q <= TRAILER_KEY_SYMBOL;
        end
        S_LOAD:     byte_q <= err_q ? ERROR_SYMBOL : rd_data;
        S_WAIT_TXE: if (timeout) err_q <= 1'b1;
        S_GAP: if (cnt_q == GAP_LAST) begin
          if (last_byte) begin
            idx_q     <= '0;
            section_q <= (section_q == SEC_HDR) ? SEC_PAY : SEC_TRL;
          end else begin
            idx_q <= idx_q + 9'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done        = (state_q == S_DONE);
  assign error       = done && err_q;
  assign rd_en       = (state_q == S_FETCH) && (section_q == SEC_PAY) && !err_q;
  assign rd_addr     = idx_q[7:0];
  assign FT_WR       = (state_q == S_STROBE);
  assign FT_DATA_OE  = (state_q == S_WAIT_TXE) || (state_q == S_STROBE) || (state_q == S_HOLD);
  assign FT_DATA_Out = byte_q;

endmodule
